psum_accumulator: RTL and testbench

- Sequential stage directly downstream of the combinational adder tree.
- Accepts one LEN-bit tree sum per beat over a configured number of tiles, and accumulates them into a wider ACC_LEN register.
- Presents the final total on a valid/ready output with a sticky overflow flag.
- Lets a long dot-product be reduced in tiles of NUM elements by a fixed-size tree.

---
 rtl/psum_accumulator_pkg.sv | 15 +
 rtl/psum_accumulator.sv | 119 +++++++++++
 tb/tb_psum_accumulator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared constants for the partial-sum accumulator and the adder tree feeding it.
// State encoding is fixed so checkers and waveforms can decode it directly.
package psum_accumulator_pkg;

  localparam int DEF_LEN       = 16;
  localparam int DEF_ACC_LEN   = 32;
  localparam int DEF_MAX_TILES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/psum_accumulator.sv
// Accumulates one unsigned tree sum per beat over a configured tile count and
// presents the wrapped total plus a sticky carry-out flag on a valid/ready port.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int LEN       = DEF_LEN,
  parameter int ACC_LEN   = DEF_ACC_LEN,
  parameter int MAX_TILES = DEF_MAX_TILES,
  parameter int CNT_W     = $clog2(MAX_TILES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   cfg_tiles,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEN-1:0]     in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_LEN-1:0] out_acc,
  output logic               out_ovf,
  output logic               busy
);

  // Handshake rule on both ports: a transfer happens on a rising clock edge
  // where valid and ready are both high; in_ready/out_valid depend on state only.

  state_t             state;
  state_t             state_next;
  logic [ACC_LEN-1:0] acc;
  logic               ovf;
  logic [CNT_W-1:0]   remaining;

  logic               beat;
  logic               last_beat;
  logic               out_fire;
  logic [ACC_LEN:0]   sum_ext;

  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (remaining == CNT_W'(1));
  assign out_fire  = out_valid && out_ready;

  // One spare bit on the left captures the carry-out of the wrap.
  assign sum_ext = {1'b0, acc} + {{(ACC_LEN + 1 - LEN){1'b0}}, in_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (cfg_tiles == '0) ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (last_beat) begin
          state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_fire) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACCUM);
    out_valid = (state == ST_OUTPUT);
    busy      = (state == ST_ACCUM) || (state == ST_OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= cfg_tiles;
            // An empty job publishes zero straight away.
            if (cfg_tiles == '0) begin
              out_acc <= '0;
              out_ovf <= 1'b0;
            end
          end
        end
        ST_ACCUM: begin
          if (beat) begin
            acc       <= sum_ext[ACC_LEN-1:0];
            ovf       <= ovf | sum_ext[ACC_LEN];
            remaining <= remaining - CNT_W'(1);
            if (last_beat) begin
              out_acc <= sum_ext[ACC_LEN-1:0];
              out_ovf <= ovf | sum_ext[ACC_LEN];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 32-bit and a 17-bit accumulator share
// all inputs so the same jobs exercise both the no-wrap and wrap paths.
module tb_psum_accumulator;
  import psum_accumulator_pkg::*;

  localparam int LEN       = 16;
  localparam int MAX_TILES = 4096;
  localparam int CNT_W     = $clog2(MAX_TILES + 1);
  localparam int W         = 51;

  typedef struct packed {
    logic [CNT_W-1:0]  tiles;
    logic [7:0][15:0]  sums;
    logic [3:0]        gap;
    logic [3:0]        hold;
    logic [31:0]       acc32;
    logic              ovf32;
    logic [16:0]       acc17;
    logic              ovf17;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_tiles = '0;
  logic             in_valid = 1'b0;
  logic [LEN-1:0]   in_sum = '0;
  logic             out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [31:0] out_acc;
  logic        in_ready17, out_valid17, out_ovf17, busy17;
  logic [16:0] out_acc17;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[8];

  psum_accumulator #(.LEN(LEN), .ACC_LEN(32), .MAX_TILES(MAX_TILES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_tiles(cfg_tiles),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  psum_accumulator #(.LEN(LEN), .ACC_LEN(17), .MAX_TILES(MAX_TILES)) dut17 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_tiles(cfg_tiles),
    .in_valid(in_valid), .in_ready(in_ready17), .in_sum(in_sum),
    .out_valid(out_valid17), .out_ready(out_ready), .out_acc(out_acc17),
    .out_ovf(out_ovf17), .busy(busy17)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (rst_n && start && !busy) begin
      assert (cfg_tiles <= CNT_W'(MAX_TILES))
        else $error("cfg_tiles %0d exceeds MAX_TILES", cfg_tiles);
    end
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int tiles, input logic [127:0] s, input int gap,
                              input int hold, input logic [31:0] a32, input logic o32,
                              input logic [16:0] a17, input logic o17);
    vec_t v;
    v.tiles = CNT_W'(tiles);
    v.sums  = s;
    v.gap   = 4'(gap);
    v.hold  = 4'(hold);
    v.acc32 = a32;
    v.ovf32 = o32;
    v.acc17 = a17;
    v.ovf17 = o17;
    return v;
  endfunction

  // driver: runs one complete job, checking latency, hold and handshake
  task automatic run_vec(input vec_t v);
    logic [W-1:0] exp;
    exp_q.push_back({v.ovf17, v.acc17, v.ovf32, v.acc32});
    @(negedge clk);
    start = 1'b1;
    cfg_tiles = v.tiles;
    @(negedge clk);
    start = 1'b0;
    if (v.tiles != 0) begin
      check("accum_in_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < int'(v.tiles); i++) begin
        in_valid = 1'b1;
        in_sum = v.sums[i];
        @(negedge clk);
        in_valid = 1'b0;
        if (i < int'(v.tiles) - 1) begin
          check("no_early_valid", {63'd0, out_valid}, 64'd0);
          for (int g = 0; g < int'(v.gap); g++) begin
            @(negedge clk);
            check("bubble_in_ready", {63'd0, in_ready}, 64'd1);
          end
        end
      end
    end
    check("out_valid_latency", {63'd0, out_valid}, 64'd1);
    check("out_valid17_latency", {63'd0, out_valid17}, 64'd1);
    check("output_in_ready", {63'd0, in_ready}, 64'd0);
    check("output_busy", {63'd0, busy}, 64'd1);
    exp = exp_q.pop_front();
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_acc", {32'd0, out_acc}, {32'd0, exp[31:0]});
    end
    check("acc32", {32'd0, out_acc}, {32'd0, exp[31:0]});
    check("ovf32", {63'd0, out_ovf}, {63'd0, exp[32]});
    check("acc17", {47'd0, out_acc17}, {47'd0, exp[49:33]});
    check("ovf17", {63'd0, out_ovf17}, {63'd0, exp[50]});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", {63'd0, out_valid}, 64'd0);
    check("post_hs_busy", {63'd0, busy}, 64'd0);
    check("post_hs_acc_kept", {32'd0, out_acc}, {32'd0, exp[31:0]});
  endtask

  initial begin
    // 17-bit results wrap mod 2^17: FFFF*3 = 2FFFD -> 0FFFD with carry.
    vecs[0] = mk(4, {16'd400, 16'd300, 16'd200, 16'd100}, 0, 0, 32'd1000, 1'b0, 17'd1000, 1'b0);
    vecs[1] = mk(3, {16'd1000, 16'd4321, 16'd1234}, 2, 5, 32'd6555, 1'b0, 17'd6555, 1'b0);
    vecs[2] = mk(3, {16'hFFFF, 16'hFFFF, 16'hFFFF}, 0, 0, 32'h2FFFD, 1'b0, 17'h0FFFD, 1'b1);
    vecs[3] = mk(1, {16'd5}, 0, 0, 32'd5, 1'b0, 17'd5, 1'b0);
    vecs[4] = mk(0, 128'd0, 0, 1, 32'd0, 1'b0, 17'd0, 1'b0);
    vecs[5] = mk(8, {8{16'hFFFF}}, 1, 2, 32'h7FFF8, 1'b0, 17'h1FFF8, 1'b1);
    vecs[6] = mk(2, {16'h0001, 16'hFFFF}, 0, 0, 32'h10000, 1'b0, 17'h10000, 1'b0);
    vecs[7] = mk(3, {16'h0002, 16'hFFFF, 16'hFFFF}, 0, 0, 32'h20000, 1'b0, 17'h00000, 1'b1);

    // reset state
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_acc", {32'd0, out_acc}, 64'd0);
    check("rst_out_ovf", {63'd0, out_ovf17}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // reset mid-job after 3 beats; previous job left out_ovf17 set
    @(negedge clk);
    start = 1'b1;
    cfg_tiles = CNT_W'(8);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sum = 16'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_out_acc", {32'd0, out_acc}, 64'd0);
    check("midrst_out_ovf17", {63'd0, out_ovf17}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(2, {16'd9, 16'd7}, 0, 0, 32'd16, 1'b0, 17'd16, 1'b0));

    // start ignored in ACCUM, in OUTPUT and on the handshake cycle
    @(negedge clk);
    start = 1'b1;
    cfg_tiles = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_sum = 16'd10;
    @(negedge clk);
    start = 1'b1;
    cfg_tiles = CNT_W'(1);
    in_sum = 16'd20;
    @(negedge clk);
    start = 1'b0;
    check("ign_accum_valid", {63'd0, out_valid}, 64'd0);
    check("ign_accum_ready", {63'd0, in_ready}, 64'd1);
    in_sum = 16'd30;
    @(negedge clk);
    in_valid = 1'b0;
    check("ign_out_valid", {63'd0, out_valid}, 64'd1);
    check("ign_out_acc", {32'd0, out_acc}, 64'd60);
    start = 1'b1;
    cfg_tiles = CNT_W'(2);
    @(negedge clk);
    check("ign_output_start", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("ign_hs_busy", {63'd0, busy}, 64'd0);
    check("ign_hs_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("ign_idle_stays", {63'd0, busy}, 64'd0);
    check("ign_idle_ready", {63'd0, in_ready}, 64'd0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
